maxpool2x2_stream: RTL

- Streaming 2x2, stride-2 max-pooling stage directly downstream of the pointwise-conv/ReLU unit.
- Consumes one feature-map channel, one pixel per valid beat, in raster order: row-major, col 0 first.
- Emits the pooled map in raster order, one pooled pixel per completed 2x2 window.
- Inputs are already ReLU'd and clipped (0..MAX), so all compares are unsigned.

---
 rtl/nn_pkg.sv | 19 +
 rtl/maxpool2x2_stream_if.sv | 15 +
 rtl/pool_line_buf.sv | 21 ++
 rtl/maxpool2x2_stream.sv | 91 +++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the pooling datapath: default geometry and the unsigned max helper.
package nn_pkg;

  localparam int N_DEF      = 16;
  localparam int IMG_W_DEF  = 24;
  localparam int IMG_H_DEF  = 24;
  localparam int POOL_W     = IMG_W_DEF / 2;
  localparam int POOL_H     = IMG_H_DEF / 2;
  localparam int COL_W      = $clog2(IMG_W_DEF);
  localparam int ROW_W      = $clog2(IMG_H_DEF);
  localparam int LB_AW      = $clog2(POOL_W);
  localparam int MAX_N      = 32;

  // Operands are zero-extended by the caller, so any N up to MAX_N shares this one helper.
  function automatic logic [MAX_N-1:0] umax(input logic [MAX_N-1:0] a, input logic [MAX_N-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Pixel stream bundle between the conv/ReLU stage and the 2x2 pooling stage.
interface maxpool2x2_stream_if #(
    parameter int N = 16
);
    logic         clr;
    logic         din_vld;
    logic [N-1:0] din;
    logic [N-1:0] dout;
    logic         dout_vld;
    logic         dout_end;
    logic         busy;

    modport master (output clr, din_vld, din, input dout, dout_vld, dout_end, busy);
    modport slave  (input clr, din_vld, din, output dout, dout_vld, dout_end, busy);
endinterface

// File: rtl/pool_line_buf.sv
// Half-width line buffer holding the horizontal maxima of the last even row.
module pool_line_buf #(
    parameter int N     = 16,
    parameter int DEPTH = 12,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [N-1:0]  wdata,
    output logic [N-1:0]  rdata
);
    logic [N-1:0] mem [DEPTH];

    // NOTE: no reset on the array; every entry is written in an even row before an odd row reads it.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over one raster-ordered channel, one pixel per valid beat.
module maxpool2x2_stream
    import nn_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    maxpool2x2_stream_if.slave    s
);
    localparam int PW  = IMG_W / 2;
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int LAW = (PW > 1) ? $clog2(PW) : 1;

    logic [CW-1:0]  col_cnt;
    logic [RW-1:0]  row_cnt;
    logic [N-1:0]   pair_r;
    logic [N-1:0]   dout_r;
    logic           dout_vld_r;
    logic           dout_end_r;
    logic [N-1:0]   hmax;
    logic [N-1:0]   lb_rdata;
    logic [LAW-1:0] lb_addr;
    logic           accept;
    logic           col_last;
    logic           row_last;
    logic           lb_we;

    assign accept   = s.din_vld & ~s.clr;
    assign col_last = (col_cnt == CW'(IMG_W - 1));
    assign row_last = (row_cnt == RW'(IMG_H - 1));
    assign hmax     = N'(umax(MAX_N'(pair_r), MAX_N'(s.din)));
    assign lb_addr  = LAW'(col_cnt >> 1);
    // Even rows only write and odd rows only read, so one port never sees both at an address.
    assign lb_we    = accept & col_cnt[0] & ~row_cnt[0];

    pool_line_buf #(
        .N     (N),
        .DEPTH (PW),
        .AW    (LAW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .addr  (lb_addr),
        .wdata (hmax),
        .rdata (lb_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            pair_r     <= '0;
            dout_r     <= '0;
            dout_vld_r <= 1'b0;
            dout_end_r <= 1'b0;
        end else begin
            dout_vld_r <= 1'b0;
            dout_end_r <= 1'b0;
            if (s.clr) begin
                col_cnt <= '0;
                row_cnt <= '0;
                pair_r  <= '0;
            end else if (s.din_vld) begin
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end

                if (!col_cnt[0]) begin
                    pair_r <= s.din;
                end else if (row_cnt[0]) begin
                    dout_r     <= N'(umax(MAX_N'(lb_rdata), MAX_N'(hmax)));
                    dout_vld_r <= 1'b1;
                    dout_end_r <= row_last & col_last;
                end
            end
        end
    end

    assign s.dout     = dout_r;
    assign s.dout_vld = dout_vld_r;
    assign s.dout_end = dout_end_r;
    assign s.busy     = (col_cnt != '0) || (row_cnt != '0);
endmodule
